// File: rtl/pmt_timebin_packer_if.sv
// Transmit handshake between the timebin packer (master) and the UART (slave).
// The packer raises transmit with the payload; the UART answers with is_transmitting, then tx_Done.
interface pmt_timebin_packer_if;
  logic        transmit;
  logic [15:0] tx_byte;
  logic        TwoBytes;
  logic        is_transmitting;
  logic        tx_Done;

  modport master (
    output transmit,
    output tx_byte,
    output TwoBytes,
    input  is_transmitting,
    input  tx_Done
  );

  modport slave (
    input  transmit,
    input  tx_byte,
    input  TwoBytes,
    output is_transmitting,
    output tx_Done
  );
endinterface

// File: rtl/pmt_timebin_packer.sv
// Counts PMT pulses per timebin, packs each closed bin into a 1/2-byte word and queues it for the UART.
// Pin-to-count 3 clk, close-to-level 1 clk; a full FIFO drops the bin and sets sticky overflow.
module pmt_timebin_packer #(
  parameter int CLK_PER_UNIT = 5000,
  parameter int FIFO_AW      = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_enable,
  input  logic                 i_pmt1_in,
  input  logic                 i_pmt2_in,
  input  logic [7:0]           i_timebinfactor,
  input  logic [1:0]           i_mode,
  pmt_timebin_packer_if.master uart,
  output logic                 o_bin_strobe,
  output logic                 o_overflow,
  output logic [FIFO_AW:0]     o_fifo_level
);

  localparam int                PW         = (CLK_PER_UNIT > 1) ? $clog2(CLK_PER_UNIT) : 1;
  localparam logic [PW-1:0]     PRESC_LAST = PW'(CLK_PER_UNIT - 1);
  localparam int                DEPTH      = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]  LEVEL_FULL = (FIFO_AW + 1)'(DEPTH);

  typedef struct packed {
    logic        two;
    logic [15:0] dat;
  } entry_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_REQ,
    TX_WAIT
  } tx_state_e;

  logic [1:0]       r_sync1, r_sync2;
  logic             r_prev1, r_prev2;
  logic             w_edge1, w_edge2;
  logic [PW-1:0]    r_presc;
  logic [7:0]       r_unit;
  logic [7:0]       r_len;
  logic [7:0]       w_len;
  logic             w_unit_end;
  logic             w_close;
  logic [7:0]       r_c1, r_c2;
  logic [8:0]       w_sum9;
  logic [7:0]       w_sum_sat;
  entry_t           w_entry;
  entry_t           r_mem [DEPTH];
  logic [FIFO_AW:0] r_wptr, r_rptr;
  logic [FIFO_AW:0] w_level;
  logic             w_full, w_empty;
  logic             w_push, w_pop;
  logic             r_overflow;
  logic [15:0]      r_tx_byte;
  logic             r_two;
  tx_state_e        r_state, w_next;
  logic             w_transmit;

  // Two-flop synchronizers; r_prev* holds the last synchronized level for edge detection.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 2'b00;
      r_sync2 <= 2'b00;
      r_prev1 <= 1'b0;
      r_prev2 <= 1'b0;
    end else begin
      r_sync1 <= {r_sync1[0], i_pmt1_in};
      r_sync2 <= {r_sync2[0], i_pmt2_in};
      r_prev1 <= r_sync1[1];
      r_prev2 <= r_sync2[1];
    end
  end

  assign w_edge1 = r_sync1[1] & ~r_prev1;
  assign w_edge2 = r_sync2[1] & ~r_prev2;

  assign w_len      = (i_timebinfactor == 8'd0) ? 8'd1 : i_timebinfactor;
  assign w_unit_end = (r_presc == PRESC_LAST);
  assign w_close    = i_enable & ~i_rst & w_unit_end & (r_unit == r_len - 8'd1);

  // Bin length is captured while idle and at every close, so a mid-bin change waits for the next bin.
  always_ff @(posedge i_clk) begin
    if (i_rst || !i_enable) begin
      r_presc <= '0;
      r_unit  <= 8'd0;
      r_len   <= w_len;
    end else if (w_unit_end) begin
      r_presc <= '0;
      if (r_unit == r_len - 8'd1) begin
        r_unit <= 8'd0;
        r_len  <= w_len;
      end else begin
        r_unit <= r_unit + 8'd1;
      end
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  // An edge seen in the close cycle belongs to the bin that starts next.
  always_ff @(posedge i_clk) begin
    if (i_rst || !i_enable) begin
      r_c1 <= 8'd0;
      r_c2 <= 8'd0;
    end else if (w_close) begin
      r_c1 <= {7'd0, w_edge1};
      r_c2 <= {7'd0, w_edge2};
    end else begin
      if (w_edge1 && r_c1 != 8'hFF) r_c1 <= r_c1 + 8'd1;
      if (w_edge2 && r_c2 != 8'hFF) r_c2 <= r_c2 + 8'd1;
    end
  end

  assign w_sum9    = {1'b0, r_c1} + {1'b0, r_c2};
  assign w_sum_sat = w_sum9[8] ? 8'hFF : w_sum9[7:0];

  always_comb begin
    w_entry = '0;
    case (i_mode)
      2'd0:    w_entry = '{two: 1'b0, dat: {8'h00, r_c1}};
      2'd1:    w_entry = '{two: 1'b0, dat: {8'h00, r_c2}};
      2'd2:    w_entry = '{two: 1'b0, dat: {8'h00, w_sum_sat}};
      default: w_entry = '{two: 1'b1, dat: {r_c2, r_c1}};
    endcase
  end

  assign w_level = r_wptr - r_rptr;
  assign w_full  = (w_level == LEVEL_FULL);
  assign w_empty = (w_level == '0);
  assign w_pop   = (r_state == TX_IDLE) & ~w_empty;
  assign w_push  = w_close & (~w_full | w_pop);

  // When full with a simultaneous pop both pointers address the same slot; the read sees the old word.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr[FIFO_AW-1:0]] <= w_entry;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_overflow <= 1'b0;
      r_tx_byte  <= 16'h0000;
      r_two      <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop) begin
        r_rptr    <= r_rptr + 1'b1;
        r_tx_byte <= r_mem[r_rptr[FIFO_AW-1:0]].dat;
        r_two     <= r_mem[r_rptr[FIFO_AW-1:0]].two;
      end
      if (w_close && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= TX_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_transmit = 1'b0;
    case (r_state)
      TX_IDLE: begin
        if (!w_empty) w_next = TX_REQ;
      end
      TX_REQ: begin
        w_transmit = 1'b1;
        if (uart.is_transmitting) w_next = TX_WAIT;
      end
      TX_WAIT: begin
        if (uart.tx_Done) w_next = TX_IDLE;
      end
      default: w_next = TX_IDLE;
    endcase
  end

  assign uart.transmit = w_transmit;
  assign uart.tx_byte  = r_tx_byte;
  assign uart.TwoBytes = r_two;
  assign o_bin_strobe  = w_close;
  assign o_overflow    = r_overflow;
  assign o_fifo_level  = w_level;

endmodule

// File: tb/tb_pmt_timebin_packer.sv
// Bench for pmt_timebin_packer: directed vector table, corner-case sequences and a randomized run
// against a cycle-count reference model (CLK_PER_UNIT=10, FIFO depth 4).
module tb_pmt_timebin_packer;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       pmt1, pmt2;
  logic [7:0] tbf;
  logic [1:0] mode;
  logic       bin_strobe, overflow;
  logic [2:0] fifo_level;

  pmt_timebin_packer_if uif ();

  pmt_timebin_packer #(.CLK_PER_UNIT(10), .FIFO_AW(2)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_enable       (enable),
    .i_pmt1_in      (pmt1),
    .i_pmt2_in      (pmt2),
    .i_timebinfactor(tbf),
    .i_mode         (mode),
    .uart           (uif.master),
    .o_bin_strobe   (bin_strobe),
    .o_overflow     (overflow),
    .o_fifo_level   (fifo_level)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic        s_strobe, s_ovf, s_tx, s_two;
  logic [2:0]  s_lvl;
  logic [15:0] s_byte;

  typedef struct {
    logic [1:0]  mode;
    int          n1;
    int          n2;
    logic [7:0]  factor;
    logic [15:0] exp_byte;
    logic        exp_two;
  } vec_t;

  typedef struct {
    bit        two;
    bit [15:0] dat;
  } ent_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Inputs for the current cycle are already driven; sample this cycle, then move into the next.
  task automatic step();
    #1;
    s_strobe = bin_strobe;
    s_ovf    = overflow;
    s_lvl    = fifo_level;
    s_tx     = uif.transmit;
    s_byte   = uif.tx_byte;
    s_two    = uif.TwoBytes;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; pmt1 = 1'b0; pmt2 = 1'b0;
    uif.is_transmitting = 1'b0; uif.tx_Done = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic handshake(input string nm);
    uif.is_transmitting = 1'b1;
    step();
    step();
    check({nm, "_tx_fall"}, s_tx, 1'b0);
    uif.is_transmitting = 1'b0;
    uif.tx_Done = 1'b1;
    step();
    uif.tx_Done = 1'b0;
  endtask

  task automatic wait_tx(input string nm);
    bit ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      step();
      if (s_tx) ok = 1;
    end
    check({nm, "_tx_seen"}, ok, 1'b1);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int    L = (v.factor == 8'd0) ? 1 : int'(v.factor);
    int    close_t = -1;
    string nm = $sformatf("vec%0d", idx);
    tbf = v.factor; mode = v.mode;
    do_reset();
    enable = 1'b1;
    for (int t = 0; t < L * 10 + 5; t++) begin
      pmt1 = (t < 2 * v.n1) && (t % 2 == 0);
      pmt2 = (t < 2 * v.n2) && (t % 2 == 0);
      if (close_t >= 0) enable = 1'b0;
      step();
      if (s_strobe && close_t < 0) close_t = t;
    end
    check({nm, "_close_t"}, close_t, L * 10 - 1);
    check({nm, "_transmit"}, s_tx, 1'b1);
    check({nm, "_tx_byte"}, s_byte, v.exp_byte);
    check({nm, "_TwoBytes"}, s_two, v.exp_two);
    handshake(nm);
  endtask

  task automatic run_period(input logic [7:0] f0, input logic [7:0] f1, input int tchg,
                            input int e0, input int e1, input int e2, input string nm);
    int got[$];
    tbf = f0; mode = 2'd0;
    do_reset();
    enable = 1'b1;
    for (int t = 0; t <= e2 + 3; t++) begin
      if (t == tchg) tbf = f1;
      step();
      if (s_strobe) got.push_back(t);
    end
    enable = 1'b0;
    check({nm, "_n"}, got.size(), 3);
    if (got.size() == 3) begin
      check({nm, "_c0"}, got[0], e0);
      check({nm, "_c1"}, got[1], e1);
      check({nm, "_c2"}, got[2], e2);
    end
  endtask

  function automatic int sat(input int x);
    return (x > 255) ? 255 : x;
  endfunction

  task automatic run_random(input int ncyc);
    ent_t q[$];
    ent_t m_cur, e;
    bit   m_busy = 0, m_req = 0, m_ovf = 0, m_started = 0;
    int   m_start = 0, m_len = 1, c1n = 0, c2n = 0;
    bit [2:0] h1 = 3'b000, h2 = 3'b000;
    int   rph = 0, rdly = 0, rhold = 0;
    m_cur.two = 0; m_cur.dat = 16'h0000;
    tbf = 8'd2; mode = 2'd0;
    do_reset();
    enable = 1'b1;
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      bit close = 0, d1, d2, pop, push, full, nreq, nbusy;
      int rel;
      if ($urandom_range(0, 299) == 0) enable = ~enable;
      rel = cyc - m_start;
      if (enable && m_started && rel >= 2 && rel <= m_len * 10 - 4 && $urandom_range(0, 15) == 0)
        tbf = 8'($urandom_range(0, 4));
      if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
      pmt1 = 1'($urandom_range(0, 1));
      pmt2 = ($urandom_range(0, 3) == 0);
      step();

      if (!enable) m_started = 0;
      else begin
        if (!m_started) begin
          m_started = 1; m_start = cyc; m_len = (tbf == 0) ? 1 : int'(tbf);
        end
        close = (cyc == m_start + m_len * 10 - 1);
      end
      check("rnd_strobe", s_strobe, close);
      check("rnd_level", s_lvl, q.size());
      check("rnd_transmit", s_tx, m_req);
      check("rnd_overflow", s_ovf, m_ovf);
      check("rnd_tx_byte", s_byte, m_cur.dat);
      check("rnd_TwoBytes", s_two, m_cur.two);

      e.two = 0; e.dat = 0;
      case (mode)
        2'd0: e.dat = 16'(sat(c1n));
        2'd1: e.dat = 16'(sat(c2n));
        2'd2: e.dat = 16'(sat(sat(c1n) + sat(c2n)));
        default: begin e.two = 1; e.dat = 16'(sat(c2n) * 256 + sat(c1n)); end
      endcase
      d1 = h1[1] & ~h1[2];
      d2 = h2[1] & ~h2[2];
      if (!enable) begin c1n = 0; c2n = 0; end
      else if (close) begin
        c1n = d1; c2n = d2;
        m_start = cyc + 1; m_len = (tbf == 0) ? 1 : int'(tbf);
      end else begin
        c1n += d1; c2n += d2;
      end

      nreq = m_req; nbusy = m_busy;
      if (m_req && uif.is_transmitting) nreq = 0;
      if (m_busy && !m_req && uif.tx_Done) nbusy = 0;
      full = (q.size() == 4);
      pop  = !m_busy && q.size() > 0;
      if (pop) begin m_cur = q.pop_front(); nbusy = 1; nreq = 1; end
      push = close && (!full || pop);
      if (close && !push) m_ovf = 1;
      if (push) q.push_back(e);
      m_req = nreq; m_busy = nbusy;
      h1 = {h1[1:0], pmt1};
      h2 = {h2[1:0], pmt2};

      uif.tx_Done = 1'b0;
      case (rph)
        0: if (s_tx) begin rdly = $urandom_range(0, 3); rph = 1; end
        1: if (rdly == 0) begin uif.is_transmitting = 1'b1; rhold = $urandom_range(3, 25); rph = 2; end
           else rdly--;
        default: if (rhold == 0) begin uif.is_transmitting = 1'b0; uif.tx_Done = 1'b1; rph = 0; end
                 else rhold--;
      endcase
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    vecs[0] = '{mode: 2'd0, n1: 5,   n2: 0,   factor: 8'd3,  exp_byte: 16'h0005, exp_two: 1'b0};
    vecs[1] = '{mode: 2'd0, n1: 300, n2: 0,   factor: 8'd70, exp_byte: 16'h00FF, exp_two: 1'b0};
    vecs[2] = '{mode: 2'd2, n1: 200, n2: 100, factor: 8'd70, exp_byte: 16'h00FF, exp_two: 1'b0};
    vecs[3] = '{mode: 2'd2, n1: 7,   n2: 9,   factor: 8'd3,  exp_byte: 16'h0010, exp_two: 1'b0};
    vecs[4] = '{mode: 2'd3, n1: 3,   n2: 12,  factor: 8'd3,  exp_byte: 16'h0C03, exp_two: 1'b1};
    vecs[5] = '{mode: 2'd1, n1: 4,   n2: 9,   factor: 8'd3,  exp_byte: 16'h0009, exp_two: 1'b0};
    vecs[6] = '{mode: 2'd2, n1: 128, n2: 128, factor: 8'd70, exp_byte: 16'h00FF, exp_two: 1'b0};

    rst = 1'b1; enable = 1'b0; pmt1 = 1'b0; pmt2 = 1'b0; tbf = 8'd3; mode = 2'd0;
    uif.is_transmitting = 1'b0; uif.tx_Done = 1'b0;
    do_reset();
    step();
    check("rst_strobe", s_strobe, 1'b0);
    check("rst_overflow", s_ovf, 1'b0);
    check("rst_level", s_lvl, 3'd0);
    check("rst_transmit", s_tx, 1'b0);
    check("rst_tx_byte", s_byte, 16'h0000);
    check("rst_TwoBytes", s_two, 1'b0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    run_period(8'd3, 8'd3, -1, 29, 59, 89, "period_f3");
    run_period(8'd0, 8'd0, -1, 9, 19, 29, "period_f0");
    run_period(8'd2, 8'd4, 5, 19, 59, 99, "factor_change");

    // Rising edges at t=3 (detected mid-bin) and t=7 (detected in the close cycle t=9) and t=15.
    tbf = 8'd1; mode = 2'd0;
    do_reset();
    enable = 1'b1;
    for (int t = 0; t < 23; t++) begin
      pmt1 = (t == 3) || (t == 7) || (t == 15);
      if (t >= 20) enable = 1'b0;
      step();
    end
    check("edge_bin1_byte", s_byte, 16'h0001);
    check("edge_level", s_lvl, 3'd1);
    handshake("edge_bin1");
    wait_tx("edge_bin2");
    check("edge_bin2_byte", s_byte, 16'h0002);
    handshake("edge_bin2");

    // Reset with three entries queued and the request stuck waiting on the UART.
    tbf = 8'd1;
    do_reset();
    enable = 1'b1;
    for (int t = 0; t < 40; t++) step();
    rst = 1'b1;
    step();
    check("midrst_level_before", s_lvl, 3'd3);
    check("midrst_tx_before", s_tx, 1'b1);
    rst = 1'b0;
    begin
      int first = -1;
      for (int t = 41; t < 60; t++) begin
        step();
        if (t == 41) begin
          check("midrst_level_after", s_lvl, 3'd0);
          check("midrst_tx_after", s_tx, 1'b0);
          check("midrst_byte_after", s_byte, 16'h0000);
        end
        if (s_strobe && first < 0) first = t;
      end
      check("midrst_first_close", first, 50);
    end

    // Overflow: UART never starts, six 10-cycle bins close.
    tbf = 8'd1;
    do_reset();
    enable = 1'b1;
    for (int t = 0; t <= 60; t++) begin
      step();
      if (t == 58) begin
        check("ovf_before", s_ovf, 1'b0);
        check("ovf_level_full", s_lvl, 3'd4);
      end
      if (t == 60) begin
        check("ovf_set", s_ovf, 1'b1);
        check("ovf_level_kept", s_lvl, 3'd4);
        check("ovf_tx_req", s_tx, 1'b1);
      end
    end
    enable = 1'b0;
    for (int t = 0; t < 20; t++) step();
    check("ovf_sticky", s_ovf, 1'b1);
    handshake("ovf_drain");
    step();
    check("ovf_sticky_drain", s_ovf, 1'b1);
    do_reset();
    step();
    check("ovf_cleared", s_ovf, 1'b0);

    run_random(3000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pmt_timebin_packer.md
# pmt_timebin_packer

Upstream feeder for the UART transmitter in the PMT timebin counting design. Counts photon pulses from two PMTs over programmable timebins, formats each closed bin into a 1- or 2-byte word, buffers the words in a FIFO and hands them one at a time to the UART (`transmit` / `tx_byte` / `TwoBytes` / `tx_Done`). Decouples bin timing from serial throughput. Flags bins lost to back-pressure.

## Interface
- `CLK_PER_UNIT`, default 5000: clk cycles per timebin unit (100 µs at 50 MHz).
- `FIFO_AW`, default 4: FIFO address width; depth = 2^FIFO_AW.
- `clk` in 1: system clock (50 MHz).
- `rst` in 1: reset; one clock, synchronous, active-high.
- `enable` in 1: counting enabled; low holds the bin timer and counters cleared.
- `pmt1_in` in 1: PMT1 pulse input, asynchronous.
- `pmt2_in` in 1: PMT2 pulse input, asynchronous.
- `timebinfactor` in 8: bin length in units; 0 is treated as 1.
- `mode` in 2: 0 = PMT1, 1 = PMT2, 2 = saturated sum, 3 = both (two bytes).
- `is_transmitting` in 1: UART busy.
- `tx_Done` in 1: one-cycle pulse from the UART after the final stop bit.
- `transmit` out 1: transmit request to the UART.
- `tx_byte` out 16: payload; [7:0] is sent first.
- `TwoBytes` out 1: payload uses both bytes.
- `bin_strobe` out 1: one-cycle pulse at every bin close.
- `overflow` out 1: sticky; a bin was dropped because the FIFO was full.
- `fifo_level` out FIFO_AW+1: number of stored entries.

## Operation
- **Input path:**
  - Each PMT input passes through a 2-FF synchronizer, then a rising-edge detector.
  - Each detected edge adds 1 to an 8-bit count (`c1`, `c2`). Counts saturate at 255.
- **Bin timer:**
  - A prescaler counts CLK_PER_UNIT cycles per unit.
  - A unit counter closes the bin after L = max(`timebinfactor`, 1) units.
  - L is latched at bin start. A change mid-bin takes effect from the next bin.
- **Bin close cycle:**
  - `bin_strobe` = 1.
  - The entry is formed from the final counts, including an edge detected in the previous cycle.
  - An edge detected in the close cycle itself counts into the new bin: counts restart at 0 or 1.
- **Entry format** (17 bits: {TwoBytes, data16}; `mode` sampled at close):
  - mode 0: {0, 8'h00, c1}
  - mode 1: {0, 8'h00, c2}
  - mode 2: {0, 8'h00, min(c1+c2, 255)}; the sum is computed 9-bit, then saturated.
  - mode 3: {1, c2, c1}
- **FIFO push:**
  - Occurs at bin close.
  - If full and no pop in the same cycle: the entry is dropped and `overflow` is set until `rst`.
  - Push and pop in the same cycle when full: both are accepted and the level is unchanged.
- **`enable` low:**
  - Prescaler, unit counter and counts are held at 0; no pushes.
  - The FIFO keeps draining.
  - On the `enable` rising edge, the first bin starts on that cycle.
- **TX FSM:**
  - **TX_IDLE:**
    - FIFO non-empty: pop and register the entry into `tx_byte`/`TwoBytes`, assert `transmit`, go to TX_REQ.
  - **TX_REQ:**
    - `transmit` is held high until `is_transmitting` = 1.
    - Then deassert `transmit` and go to TX_WAIT.
    - The request survives a blocked UART (StopUART) indefinitely.
  - **TX_WAIT:**
    - On `tx_Done` = 1, go to TX_IDLE.
    - `tx_byte`/`TwoBytes` stay stable until the next pop.
- **Reset mid-operation:**
  - FIFO emptied, counts and timer cleared, FSM to TX_IDLE, `transmit` dropped immediately.
  - A frame already in progress in the UART is not aborted by this block.

## Timing
- Reset values:
  - `transmit`, `TwoBytes`, `bin_strobe`, `overflow` = 0
  - `tx_byte` = 16'h0000
  - `fifo_level` = 0
- Pin edge to count increment: 3 cycles (2 sync + edge register).
- Bin length: exactly L·CLK_PER_UNIT cycles, close to close, with no gap between bins.
- Bin close to `fifo_level` increment: 1 cycle.
- FIFO non-empty to `transmit` high, with `tx_byte` valid in the same cycle: 1 cycle.
- No pop in the cycle of a push into an empty FIFO. The FIFO is not show-ahead, so the earliest pop is the following cycle.
- `transmit` high for at least 1 cycle; it falls the cycle after `is_transmitting` is seen high.
- Next pop no earlier than 1 cycle after `tx_Done`.

## Test plan
- **Single-PMT counting** (CLK_PER_UNIT = 10, factor 3, mode 0, 5 pulses on `pmt1_in`): `bin_strobe` every 30 cycles; `transmit` with `tx_byte` = 16'h0005, `TwoBytes` = 0.
- **Saturation and sum:**
  - 300 PMT1 pulses in one bin, mode 0: `tx_byte`[7:0] = 255.
  - 200 + 100 pulses, mode 2: 255.
  - 7 + 9 pulses, mode 2: 16.
- **Two-byte mode** (mode 3, c1 = 3, c2 = 12): `tx_byte` = 16'h0C03, `TwoBytes` = 1; next pop only after `tx_Done`.
- **Overflow** (FIFO_AW = 2, `is_transmitting` stuck 0 so the UART never starts, 6 bins closed): the first entry is popped into TX_REQ, the FIFO fills to 4, the sixth bin is dropped, `overflow` = 1 and stays 1 until `rst`.
- **Boundary:**
  - Pulse detected in the close cycle is counted in the next bin.
  - `timebinfactor` = 0 gives 10-cycle bins.
  - Factor changed mid-bin applies to the next bin only.
- **Reset mid-operation** (`rst` asserted with 3 entries queued and TX in TX_REQ): next cycle `fifo_level` = 0, `transmit` = 0; after release, the first bin closes exactly L·CLK_PER_UNIT cycles later.
